// File: rtl/pipelined_subber.sv
// Two-stage valid/ready unsigned subtractor: DOut1 - DOut2 with wrap, saturate
// and absolute-difference modes, borrow/zero flags and a running borrow counter.
module pipelined_subber #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     DOut1,
    input  logic [WIDTH-1:0]     DOut2,
    input  logic [1:0]           Mode,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WIDTH-1:0]     SUBOut,
    output logic                 Borrow,
    output logic                 Zero,
    output logic [CNT_WIDTH-1:0] BorrowCnt,
    input  logic                 CntClr
);

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Stage 1: captured operands, mode and raw WIDTH+1 bit difference.
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    mode_e            s1_mode_q, s1_mode_d;
    logic [WIDTH:0]   s1_diff_q, s1_diff_d;

    // Stage 2: mode-applied result and flags presented at the output.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_borrow_q, s2_borrow_d;
    logic             s2_zero_q, s2_zero_d;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic             s1_adv, s2_adv, in_fire, out_fire;
    logic             s1_borrow;
    logic [WIDTH-1:0] s1_res;

    // Ready flows backward from OutReady only; InValid never feeds InReady.
    always_comb begin
        s2_adv   = !s2_valid_q || OutReady;
        s1_adv   = !s1_valid_q || s2_adv;
        in_fire  = InValid && s1_adv;
        out_fire = s2_valid_q && OutReady;
    end

    assign InReady = s1_adv;

    // NOTE: every always_comb output gets a hold/default value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s1_diff_d  = s1_diff_q;
        if (s1_adv) begin
            s1_valid_d = InValid;
        end
        if (in_fire) begin
            s1_a_d    = DOut1;
            s1_b_d    = DOut2;
            s1_mode_d = mode_e'(Mode);
            s1_diff_d = {1'b0, DOut1} - {1'b0, DOut2};
        end
    end

    always_comb begin
        s1_borrow = s1_diff_q[WIDTH];
        case (s1_mode_q)
            MODE_SAT: s1_res = s1_borrow ? '0 : s1_diff_q[WIDTH-1:0];
            MODE_ABS: s1_res = s1_borrow ? (s1_b_q - s1_a_q) : (s1_a_q - s1_b_q);
            default:  s1_res = s1_diff_q[WIDTH-1:0];
        endcase
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_borrow_d = s2_borrow_q;
        s2_zero_d   = s2_zero_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d    = s1_res;
                s2_borrow_d = s1_borrow;
                s2_zero_d   = (s1_res == '0);
            end
        end
    end

    // Clear wins over a same-cycle borrowing transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (CntClr) begin
            cnt_d = '0;
        end else if (out_fire && s2_borrow_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: data registers are reset too, not just valids, because the outputs must read zero during reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= MODE_WRAP;
            s1_diff_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_borrow_q <= 1'b0;
            s2_zero_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s1_diff_q   <= s1_diff_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_borrow_q <= s2_borrow_d;
            s2_zero_q   <= s2_zero_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid  = s2_valid_q;
    assign SUBOut    = s2_res_q;
    assign Borrow    = s2_borrow_q;
    assign Zero      = s2_zero_q;
    assign BorrowCnt = cnt_q;

endmodule

// File: tb/tb_pipelined_subber.sv
// Scoreboard bench for pipelined_subber: randomized and directed stimulus,
// expected results from an arithmetic reference model, checked by monitors.
module tb_pipelined_subber;

    localparam int W  = 8;
    localparam int C  = 16;
    localparam int W2 = 16;
    localparam int C2 = 2;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          InValid, InReady, OutValid, OutReady, Borrow, Zero, CntClr;
    logic [W-1:0]  DOut1, DOut2, SUBOut;
    logic [1:0]    Mode;
    logic [C-1:0]  BorrowCnt;

    logic          InValid_w, InReady_w, OutValid_w, OutReady_w, Borrow_w, Zero_w, CntClr_w;
    logic [W2-1:0] DOut1_w, DOut2_w, SUBOut_w;
    logic [1:0]    Mode_w;
    logic [C2-1:0] BorrowCnt_w;

    always #5 Clk = ~Clk;

    pipelined_subber #(.WIDTH(W), .CNT_WIDTH(C)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .DOut1(DOut1), .DOut2(DOut2), .Mode(Mode), .OutValid(OutValid),
        .OutReady(OutReady), .SUBOut(SUBOut), .Borrow(Borrow), .Zero(Zero),
        .BorrowCnt(BorrowCnt), .CntClr(CntClr)
    );

    pipelined_subber #(.WIDTH(W2), .CNT_WIDTH(C2)) u_dut_w (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid_w), .InReady(InReady_w),
        .DOut1(DOut1_w), .DOut2(DOut2_w), .Mode(Mode_w), .OutValid(OutValid_w),
        .OutReady(OutReady_w), .SUBOut(SUBOut_w), .Borrow(Borrow_w), .Zero(Zero_w),
        .BorrowCnt(BorrowCnt_w), .CntClr(CntClr_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic         borrow;
        logic         zero;
    } exp_t;

    typedef struct {
        logic [W2-1:0] res;
        logic          borrow;
    } exp_w_t;

    exp_t   sb_q[$];
    exp_w_t sb_w[$];
    int     exp_cnt = 0;
    int     occ     = 0;

    // Reference model: plain unsigned arithmetic on the operands.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned m);
        exp_t        e;
        int unsigned r;
        e.borrow = (a < b);
        case (m)
            1:       r = (a < b) ? 0 : a - b;
            2:       r = (a < b) ? b - a : a - b;
            default: r = (a - b) & 32'hFF;
        endcase
        e.res  = r[W-1:0];
        e.zero = (r[W-1:0] == 0);
        return e;
    endfunction

    // Main monitor: output scoreboard, occupancy-based ready check, counter model.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("rst_out_valid", 32'(OutValid), 0);
            check("rst_sub_out", 32'(SUBOut), 0);
            check("rst_borrow", 32'(Borrow), 0);
            check("rst_zero", 32'(Zero), 0);
            check("rst_borrow_cnt", 32'(BorrowCnt), 0);
            check("rst_in_ready", 32'(InReady), 1);
            sb_q.delete();
            exp_cnt = 0;
            occ     = 0;
        end else begin
            logic out_xfer, in_xfer, xfer_borrow;
            out_xfer    = 1'b0;
            xfer_borrow = 1'b0;
            in_xfer     = InValid && InReady;
            check("in_ready", 32'(InReady), 32'(!(occ == 2 && !OutReady)));
            check("borrow_cnt", 32'(BorrowCnt), exp_cnt);
            if (sb_q.size() == 0) begin
                check("no_spurious_out", 32'(OutValid), 0);
            end else if (OutValid) begin
                check("sub_out", 32'(SUBOut), 32'(sb_q[0].res));
                check("borrow", 32'(Borrow), 32'(sb_q[0].borrow));
                check("zero", 32'(Zero), 32'(sb_q[0].zero));
                if (OutReady) begin
                    out_xfer    = 1'b1;
                    xfer_borrow = sb_q[0].borrow;
                    void'(sb_q.pop_front());
                end
            end
            if (CntClr) exp_cnt = 0;
            else if (out_xfer && xfer_borrow) exp_cnt = (exp_cnt + 1) % (1 << C);
            occ = occ + int'(in_xfer) - int'(out_xfer);
            if (in_xfer) sb_q.push_back(model(32'(DOut1), 32'(DOut2), 32'(Mode)));
        end
    end

    // Wide-instance monitor (always ready downstream).
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (sb_w.size() == 0) begin
                check("w_no_spurious_out", 32'(OutValid_w), 0);
            end else if (OutValid_w) begin
                check("w_sub_out", 32'(SUBOut_w), 32'(sb_w[0].res));
                check("w_borrow", 32'(Borrow_w), 32'(sb_w[0].borrow));
                check("w_zero", 32'(Zero_w), 32'(sb_w[0].res == 0));
                void'(sb_w.pop_front());
            end
        end
    end

    logic rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;

    initial begin
        OutReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            OutReady = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        int t = 0;
        InValid = 1'b1;
        DOut1   = a;
        DOut2   = b;
        Mode    = m;
        @(negedge Clk);
        while (!InReady && t < 200) begin
            t++;
            @(negedge Clk);
        end
        check("accept_in_time", 32'(t < 200), 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        DOut1   = W'($urandom);
        DOut2   = W'($urandom);
        Mode    = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int t = 0;
        @(negedge Clk);
        while (sb_q.size() != 0 && t < 500) begin
            t++;
            @(negedge Clk);
        end
        check("drain", 32'(sb_q.size()), 0);
        @(posedge Clk);
        #1;
    endtask

    task automatic send_w(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic [1:0] m,
                          input logic [W2-1:0] res, input logic brw);
        exp_w_t e;
        InValid_w = 1'b1;
        DOut1_w   = a;
        DOut2_w   = b;
        Mode_w    = m;
        @(negedge Clk);
        check("w_in_ready", 32'(InReady_w), 1);
        if (InReady_w) begin
            e.res    = res;
            e.borrow = brw;
            sb_w.push_back(e);
        end
        @(posedge Clk);
        #1;
        InValid_w = 1'b0;
    endtask

    task automatic drain_w();
        int t = 0;
        @(negedge Clk);
        while (sb_w.size() != 0 && t < 100) begin
            t++;
            @(negedge Clk);
        end
        check("w_drain", 32'(sb_w.size()), 0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n      = 1'b0;
        InValid    = 1'b0;
        DOut1      = '0;
        DOut2      = '0;
        Mode       = 2'b00;
        CntClr     = 1'b0;
        InValid_w  = 1'b0;
        DOut1_w    = '0;
        DOut2_w    = '0;
        Mode_w     = 2'b00;
        OutReady_w = 1'b1;
        CntClr_w   = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Wrap mode, first transfer right after reset release, with latency check.
        send(8'h01, 8'h0F, 2'b00);
        @(negedge Clk);
        check("latency_cycle1_out_valid", 32'(OutValid), 0);
        @(negedge Clk);
        check("latency_cycle2_out_valid", 32'(OutValid), 1);
        @(posedge Clk);
        #1;
        send(8'h10, 8'h03, 2'b00);
        send(8'h05, 8'h05, 2'b00);
        drain();
        check("wrap_borrow_cnt", 32'(BorrowCnt), 1);

        // Saturate, absolute and reserved mode on 0x03 - 0x0A.
        send(8'h03, 8'h0A, 2'b01);
        send(8'h03, 8'h0A, 2'b10);
        send(8'h03, 8'h0A, 2'b11);
        drain();

        // Backpressure stream.
        rdy_rand = 1'b1;
        for (int i = 1; i <= 10; i++) send(W'(i), W'(16 - i), 2'b00);
        drain();
        rdy_rand = 1'b0;

        // Fill both stages with the output stalled, then release.
        rdy_val = 1'b0;
        @(posedge Clk);
        #1;
        send(8'h20, 8'h11, 2'b00);
        send(8'h11, 8'h20, 2'b10);
        InValid = 1'b1;
        DOut1   = 8'h40;
        DOut2   = 8'h41;
        Mode    = 2'b01;
        @(negedge Clk);
        check("full_in_ready", 32'(InReady), 0);
        rdy_val = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("release_in_ready", 32'(InReady), 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        drain();

        // Counter: clear, five borrows, then clear coinciding with a borrowing transfer.
        CntClr = 1'b1;
        @(posedge Clk);
        #1;
        CntClr = 1'b0;
        for (int i = 0; i < 5; i++) send(W'(i), 8'hC8, 2'($urandom_range(0, 3)));
        drain();
        check("cnt_five", 32'(BorrowCnt), 5);
        rdy_val = 1'b0;
        @(posedge Clk);
        #1;
        send(8'h01, 8'h02, 2'b00);
        rdy_val = 1'b1;
        @(posedge Clk);
        #1;
        CntClr = 1'b1;
        @(negedge Clk);
        check("clr_xfer_out_valid", 32'(OutValid), 1);
        @(posedge Clk);
        #1;
        CntClr = 1'b0;
        check("cnt_clr_priority", 32'(BorrowCnt), 0);
        drain();

        // Randomized traffic with random backpressure, modes and occasional clears.
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            CntClr = ($urandom_range(0, 15) == 0);
            send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
        end
        CntClr = 1'b0;
        drain();
        rdy_rand = 1'b0;

        // Mid-stream reset with two borrowing items in flight.
        rdy_val = 1'b0;
        @(posedge Clk);
        #1;
        send(8'h01, 8'h09, 2'b00);
        send(8'h02, 8'h09, 2'b10);
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        rdy_val = 1'b1;
        Rst_n   = 1'b1;
        repeat (6) @(negedge Clk);
        check("post_reset_cnt", 32'(BorrowCnt), 0);
        @(posedge Clk);
        #1;
        send(8'h09, 8'h02, 2'b00);
        drain();

        // WIDTH=16, CNT_WIDTH=2 instance.
        send_w(16'h0000, 16'h0001, 2'b00, 16'hFFFF, 1'b1);
        send_w(16'h0000, 16'h0001, 2'b10, 16'h0001, 1'b1);
        send_w(16'h0005, 16'h0009, 2'b01, 16'h0000, 1'b1);
        drain_w();
        check("w_cnt_three", 32'(BorrowCnt_w), 3);
        send_w(16'h1234, 16'h1235, 2'b00, 16'hFFFF, 1'b1);
        drain_w();
        check("w_cnt_wrap", 32'(BorrowCnt_w), 0);

        check("final_queue_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
